pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Parametrised program-counter sequencer for the 9-bit-ISA core. It replaces the fixed 10-bit fetch counter with a configurable-width PC, selectable program entry points, and a small return-address stack for call/return. It sits between control decode (Jump/Call/Ret/Halt/Stall) and instruction ROM (ProgCtr is the ROM address).

## Interface
- PC_W, 10, program counter and address width
- OFF_W, 10, Target width; sign-extended to PC_W for relative moves (OFF_W ≤ PC_W)
- NUM_PROGS, 4, number of program entry points
- PROG_STRIDE, 256, entry address of program k = k·PROG_STRIDE mod 2^PC_W
- RAS_DEPTH, 4, return-address stack entries (≥1)

- Clk  in  1  clock; all state changes on posedge only
- Reset  in  1  synchronous, active-high
- Start  in  1  load entry point; hold while asserted
- ProgSel  in  $clog2(NUM_PROGS) (min 1)  program index sampled with Start
- Stall  in  1  freeze PC and stack this cycle
- Jump  in  1  take branch to Target
- BranchAbsOrRel  in  1  0 = absolute Target, 1 = PC + sext(Target)
- Call  in  1  push PC+1, then branch as for Jump
- Ret  in  1  pop return address into PC
- Halt  in  1  stop sequencing
- Target  in  OFF_W  branch operand
- ProgCtr  out  PC_W  current PC (registered)
- Done  out  1  high in HALTED state
- RasOvf  out  1  sticky: Call with stack full
- RasUnf  out  1  sticky: Ret with stack empty

## Operation
- States: RUN, HOLD, HALTED. Reset → RUN, ProgCtr=0, stack empty, Done=0, RasOvf=0, RasUnf=0.
- Global priority each edge: Reset > Start > state action.
- Start (any state): ProgCtr ← ProgSel·PROG_STRIDE; stack cleared; RasOvf/RasUnf cleared; state → HOLD. ProgSel ≥ NUM_PROGS → entry 0.
- HOLD: Start low → RUN; PC unchanged that edge (first fetch at entry address).
- RUN priority: Stall > Halt > Ret > Call > Jump > increment.
  - Stall: everything holds.
  - Halt: state → HALTED, PC holds.
  - Ret, stack non-empty: ProgCtr ← top, pop. Empty: RasUnf←1, ProgCtr ← PC+1.
  - Call: dest computed as Jump; ProgCtr ← dest; push PC+1 if not full, else RasOvf←1 and no push (stack contents preserved).
  - Jump: abs → zero-extended Target; rel → PC + sext(Target).
  - Else ProgCtr ← PC+1.
- HALTED: PC, stack frozen; Done=1; only Start or Reset leaves.
- Arithmetic: all PC sums modulo 2^PC_W; PC+1 at all-ones wraps to 0, no flag.
- Simultaneous Call+Ret: Ret wins, Call ignored. Jump with Ret or Call is subsumed.

## Timing
- Single-cycle: control sampled at edge N, new ProgCtr visible after edge N; zero extra latency.
- ProgCtr, Done, flags are register outputs; no combinational input→output path.
- Stack push/pop and PC update occur on the same edge; back-to-back Call/Ret every cycle supported.
- Reset mid-operation: next edge returns to reset values regardless of Start/Stall.
- Start asserted N cycles: PC at entry for N+1 cycles (through HOLD→RUN edge).

## Structure
- Shared package pc_pkg: state enum (RUN, HOLD, HALTED), default PC_W/OFF_W constants, branch-mode encoding (ABS=0, REL=1).
- One sub-module: pc_ras (LIFO, RAS_DEPTH×PC_W, push/pop/clear, full/empty outputs). Sequencer FSM and next-PC mux stay in pc_sequencer.

## Test plan
- Reset, then 5 idle cycles → ProgCtr 0,1,2,3,4,5; Done=0, flags 0.
- Start=1 for 3 cycles with ProgSel=2 → ProgCtr=512 mod 1024=512 held 4 cycles, then 513.
- At PC=20, Jump rel Target=10'h3FB (−5) → 15; Jump abs Target=100 → 100; rel at PC=1023 with Target=2 → 1.
- Call at PC=10 to 200, Call at 200 to 300, Ret, Ret → 300, 201, 11; stack empty, no flags.
- 5 Calls with RAS_DEPTH=4 → RasOvf=1 after 5th; 5 Rets return 4 valid addresses then RasUnf=1 with PC+1.
- Halt at PC=40 with Stall low → Done=1, PC held 40 for 10 cycles despite Jump; Stall+Halt same cycle → no halt; Start exits.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter sequencer: FSM state encoding,
// default widths and the branch-mode encoding used on BranchAbsOrRel.
package pc_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HOLD   = 2'd1,
    HALTED = 2'd2
  } pc_state_e;

  localparam int PC_W_DEF  = 10;
  localparam int OFF_W_DEF = 10;

  localparam logic BR_ABS = 1'b0;
  localparam logic BR_REL = 1'b1;

endpackage

// File: rtl/pc_sequencer_if.sv
// Control-decode to sequencer bundle. The master drives the decoded
// control strobes; the slave (the sequencer) returns PC and status.
interface pc_sequencer_if #(
  parameter int PC_W  = 10,
  parameter int OFF_W = 10,
  parameter int SEL_W = 2
);
  logic             Start;
  logic [SEL_W-1:0] ProgSel;
  logic             Stall;
  logic             Jump;
  logic             BranchAbsOrRel;
  logic             Call;
  logic             Ret;
  logic             Halt;
  logic [OFF_W-1:0] Target;
  logic [PC_W-1:0]  ProgCtr;
  logic             Done;
  logic             RasOvf;
  logic             RasUnf;

  modport master (
    output Start, ProgSel, Stall, Jump, BranchAbsOrRel, Call, Ret, Halt, Target,
    input  ProgCtr, Done, RasOvf, RasUnf
  );

  modport slave (
    input  Start, ProgSel, Stall, Jump, BranchAbsOrRel, Call, Ret, Halt, Target,
    output ProgCtr, Done, RasOvf, RasUnf
  );
endinterface

// File: rtl/pc_ras.sv
// Return-address stack: a shift-register LIFO whose top is always entry 0,
// so no pointer arithmetic is needed on the read path. Pop wins over push.
module pc_ras #(
  parameter int DEPTH = 4,
  parameter int W     = 10
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         clear,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] top,
  output logic         full,
  output logic         empty
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [CW-1:0] count;

  assign top   = mem[0];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // Occupancy tracking; clear and reset only empty the stack.
  always_ff @(posedge Clk) begin
    if (Reset || clear) begin
      count <= '0;
    end else if (pop && !empty) begin
      count <= count - CW'(1);
    end else if (push && !full) begin
      count <= count + CW'(1);
    end
  end

  // Data shifts toward entry 0 on pop and away from it on push.
  always_ff @(posedge Clk) begin
    if (!Reset && !clear) begin
      if (pop && !empty) begin
        for (int i = 0; i < DEPTH - 1; i++) mem[i] <= mem[i+1];
      end else if (push && !full) begin
        mem[0] <= push_data;
        for (int i = 1; i < DEPTH; i++) mem[i] <= mem[i-1];
      end
    end
  end
endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: selectable entry points, absolute/relative
// branches, call/return through pc_ras, halt and stall.
//
//   state  | meaning
//   RUN    | fetching; PC advances, branches, calls or returns each edge
//   HOLD   | entry address loaded; waits for Start to drop, PC held
//   HALTED | PC and stack frozen, Done high until Start or Reset
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int PC_W        = PC_W_DEF,
  parameter int OFF_W       = OFF_W_DEF,
  parameter int NUM_PROGS   = 4,
  parameter int PROG_STRIDE = 256,
  parameter int RAS_DEPTH   = 4
) (
  input logic            Clk,
  input logic            Reset,
  pc_sequencer_if.slave  bus
);
  pc_state_e       state_q;
  logic [PC_W-1:0] pc_q;
  logic            done_q;
  logic            ovf_q;
  logic            unf_q;

  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] tgt_sext;
  logic [PC_W-1:0] dest;
  logic [PC_W-1:0] entry;
  logic [PC_W-1:0] ras_top;
  logic            ras_full;
  logic            ras_empty;
  logic            run_act;
  logic            ras_push;
  logic            ras_pop;

  assign pc_inc   = pc_q + PC_W'(1);
  assign tgt_sext = PC_W'($signed(bus.Target));
  assign dest     = (bus.BranchAbsOrRel == BR_REL) ? (pc_q + tgt_sext)
                                                   : PC_W'(bus.Target);

  // Entry point for the selected program; out-of-range selections map to 0.
  always_comb begin
    entry = '0;
    if (int'(bus.ProgSel) < NUM_PROGS)
      entry = PC_W'(bus.ProgSel) * PC_W'(PROG_STRIDE);
  end

  // A RUN-state edge where no higher-priority condition freezes the PC.
  assign run_act  = !Reset && !bus.Start && (state_q == RUN) && !bus.Stall && !bus.Halt;
  assign ras_pop  = run_act && bus.Ret && !ras_empty;
  assign ras_push = run_act && !bus.Ret && bus.Call && !ras_full;

  pc_ras #(.DEPTH(RAS_DEPTH), .W(PC_W)) u_ras (
    .Clk       (Clk),
    .Reset     (Reset),
    .clear     (bus.Start),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_inc),
    .top       (ras_top),
    .full      (ras_full),
    .empty     (ras_empty)
  );

  // Sequencer FSM with next-PC selection and sticky stack flags.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= RUN;
      pc_q    <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else if (bus.Start) begin
      state_q <= HOLD;
      pc_q    <= entry;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      case (state_q)
        HOLD: state_q <= RUN;
        RUN: begin
          if (bus.Stall) begin
            pc_q <= pc_q;
          end else if (bus.Halt) begin
            state_q <= HALTED;
            done_q  <= 1'b1;
          end else if (bus.Ret) begin
            if (!ras_empty) begin
              pc_q <= ras_top;
            end else begin
              pc_q  <= pc_inc;
              unf_q <= 1'b1;
            end
          end else if (bus.Call) begin
            pc_q <= dest;
            if (ras_full) ovf_q <= 1'b1;
          end else if (bus.Jump) begin
            pc_q <= dest;
          end else begin
            pc_q <= pc_inc;
          end
        end
        default: state_q <= HALTED;
      endcase
    end
  end

  assign bus.ProgCtr = pc_q;
  assign bus.Done    = done_q;
  assign bus.RasOvf  = ovf_q;
  assign bus.RasUnf  = unf_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer. Each stimulus cycle pushes its expected
// post-edge PC/Done/flags into a queue; the monitor pops and compares after
// every active edge.
module tb_pc_sequencer;
  import pc_pkg::*;

  logic Clk = 1'b0;
  logic Reset;

  always #5 Clk = ~Clk;

  pc_sequencer_if #(.PC_W(10), .OFF_W(10), .SEL_W(2)) bus ();

  pc_sequencer #(
    .PC_W(10), .OFF_W(10), .NUM_PROGS(4), .PROG_STRIDE(256), .RAS_DEPTH(4)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  typedef struct {
    int         id;
    logic [9:0] pc;
    logic       done;
    logic       ovf;
    logic       unf;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   step_id = 0;

  task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d got %0d expected %0d", nm, id, act, exp);
    end
  endtask

  // Monitor: compare DUT outputs just after each active edge.
  always @(posedge Clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("ProgCtr", e.id, 32'(bus.ProgCtr), 32'(e.pc));
      chk("Done",    e.id, 32'(bus.Done),    32'(e.done));
      chk("RasOvf",  e.id, 32'(bus.RasOvf),  32'(e.ovf));
      chk("RasUnf",  e.id, 32'(bus.RasUnf),  32'(e.unf));
    end
  end

  task automatic step(input logic rst, input logic st, input logic [1:0] sel,
                      input logic stl, input logic jmp, input logic rel,
                      input logic cl, input logic rt, input logic hl,
                      input logic [9:0] tgt,
                      input logic [9:0] epc, input logic edone,
                      input logic eovf, input logic eunf);
    exp_t e;
    @(negedge Clk);
    Reset              = rst;
    bus.Start          = st;
    bus.ProgSel        = sel;
    bus.Stall          = stl;
    bus.Jump           = jmp;
    bus.BranchAbsOrRel = rel;
    bus.Call           = cl;
    bus.Ret            = rt;
    bus.Halt           = hl;
    bus.Target         = tgt;
    step_id++;
    e.id = step_id; e.pc = epc; e.done = edone; e.ovf = eovf; e.unf = eunf;
    q.push_back(e);
    @(posedge Clk);
  endtask

  task automatic idle(input logic [9:0] epc, input logic eovf, input logic eunf);
    step(0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 10'd0, epc, 0, eovf, eunf);
  endtask

  task automatic start(input logic [1:0] sel, input logic [9:0] epc);
    step(0, 1, sel, 0, 0, 0, 0, 0, 0, 10'd0, epc, 0, 0, 0);
  endtask

  task automatic jump(input logic rel, input logic [9:0] tgt, input logic [9:0] epc);
    step(0, 0, 2'd0, 0, 1, rel, 0, 0, 0, tgt, epc, 0, 0, 0);
  endtask

  task automatic call(input logic rel, input logic [9:0] tgt, input logic [9:0] epc,
                      input logic eovf, input logic eunf);
    step(0, 0, 2'd0, 0, 1, rel, 1, 0, 0, tgt, epc, 0, eovf, eunf);
  endtask

  task automatic ret(input logic [9:0] epc, input logic eovf, input logic eunf);
    step(0, 0, 2'd0, 0, 0, 0, 0, 1, 0, 10'd0, epc, 0, eovf, eunf);
  endtask

  initial begin
    Reset = 1'b1;
    bus.Start = 0; bus.ProgSel = 0; bus.Stall = 0; bus.Jump = 0;
    bus.BranchAbsOrRel = BR_ABS; bus.Call = 0; bus.Ret = 0; bus.Halt = 0;
    bus.Target = '0;

    // Reset, then free-running increment.
    step(1, 0, 2'd0, 0, 0, 0, 0, 0, 0, 10'd0, 10'd0, 0, 0, 0);
    for (int i = 1; i <= 5; i++) idle(10'(i), 0, 0);

    // Start held 3 cycles selecting program 2: entry held 4 cycles.
    start(2'd2, 10'd512);
    start(2'd2, 10'd512);
    start(2'd2, 10'd512);
    idle(10'd512, 0, 0);
    idle(10'd513, 0, 0);

    // Absolute/relative jumps, including modular wrap.
    jump(BR_ABS, 10'd20, 10'd20);
    jump(BR_REL, 10'h3FB, 10'd15);
    jump(BR_ABS, 10'd100, 10'd100);
    jump(BR_ABS, 10'd1023, 10'd1023);
    jump(BR_REL, 10'd2, 10'd1);
    jump(BR_ABS, 10'd1023, 10'd1023);
    idle(10'd0, 0, 0);

    // Nested call/return.
    jump(BR_ABS, 10'd10, 10'd10);
    call(BR_ABS, 10'd200, 10'd200, 0, 0);
    call(BR_ABS, 10'd300, 10'd300, 0, 0);
    ret(10'd201, 0, 0);
    ret(10'd11, 0, 0);

    // Overflow on fifth call, then underflow on fifth return.
    start(2'd0, 10'd0);
    idle(10'd0, 0, 0);
    call(BR_ABS, 10'd50, 10'd50, 0, 0);
    call(BR_ABS, 10'd60, 10'd60, 0, 0);
    call(BR_ABS, 10'd70, 10'd70, 0, 0);
    call(BR_ABS, 10'd80, 10'd80, 0, 0);
    call(BR_REL, 10'd10, 10'd90, 1, 0);
    ret(10'd71, 1, 0);
    ret(10'd61, 1, 0);
    ret(10'd51, 1, 0);
    ret(10'd1, 1, 0);
    ret(10'd2, 1, 1);

    // Start clears flags; Call+Ret together: Ret wins, no push.
    start(2'd1, 10'd256);
    idle(10'd256, 0, 0);
    call(BR_ABS, 10'd400, 10'd400, 0, 0);
    step(0, 0, 2'd0, 0, 1, 0, 1, 1, 0, 10'd500, 10'd257, 0, 0, 0);
    ret(10'd258, 0, 1);

    // Halt behaviour and Stall precedence.
    start(2'd3, 10'd768);
    idle(10'd768, 0, 0);
    jump(BR_ABS, 10'd40, 10'd40);
    step(0, 0, 2'd0, 1, 0, 0, 0, 0, 1, 10'd0, 10'd40, 0, 0, 0);
    step(0, 0, 2'd0, 1, 1, 0, 0, 0, 0, 10'd5, 10'd40, 0, 0, 0);
    step(0, 0, 2'd0, 0, 0, 0, 0, 0, 1, 10'd0, 10'd40, 1, 0, 0);
    for (int i = 0; i < 10; i++)
      step(0, 0, 2'd0, 0, 1, 0, 0, 0, 0, 10'd5, 10'd40, 1, 0, 0);
    start(2'd1, 10'd256);
    idle(10'd256, 0, 0);
    idle(10'd257, 0, 0);

    // Reset overrides Start and Stall and clears a sticky flag.
    ret(10'd258, 0, 1);
    step(1, 1, 2'd2, 1, 0, 0, 0, 0, 0, 10'd0, 10'd0, 0, 0, 0);
    idle(10'd1, 0, 0);

    @(negedge Clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain pending %0d expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
